ifmap_stream_dma: RTL and testbench

//  Stream-side partner of the ping-pong ifmap buffer. Loader: reads load_len words from local SRAM
//  (1-cycle read latency), drives them into the buffer write stream without bubbles.

---
 rtl/ifmap_stream_dma.sv | 175 +++++++++++++++++
 tb/tb_ifmap_stream_dma.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_stream_dma.sv
// Stream-side DMA for the ping-pong ifmap buffer: SRAM->stream loader and stream->SRAM drainer.
// Optional `IFMAP_DMA_STALL_CNT_EN adds tx_stall_cnt (cycles of m_valid && !m_ready).
module ifmap_stream_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  drain_start,
  input  logic [ADDR_WIDTH-1:0] drain_base,
  input  logic [LEN_WIDTH-1:0]  drain_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  drain_busy,
  output logic                  drain_done,
  output logic                  drain_err
`ifdef IFMAP_DMA_STALL_CNT_EN
  ,
  output logic [15:0]           tx_stall_cnt
`endif
);

  typedef enum logic [1:0] {L_IDLE = 2'd0, L_FILL = 2'd1, L_SEND = 2'd2} load_state_t;
  typedef enum logic {D_IDLE = 1'b0, D_RUN = 1'b1} drain_state_t;

  // ---------------- loader ----------------
  load_state_t           l_state, l_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_addr;
  logic [LEN_WIDTH-1:0]  issue_left, beat_left;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]            fifo_cnt;
  logic [2:0]            fifo_occ;
  logic                  load_accept, pop, issue;

  assign load_accept = load_start && (l_state == L_IDLE);
  assign m_valid     = (l_state == L_SEND);
  assign pop         = m_valid && m_ready;
  assign m_data      = fifo_mem[fifo_rd_ptr];
  assign m_last      = m_valid && (beat_left == LEN_WIDTH'(1));
  assign load_busy   = (l_state != L_IDLE);

  // Occupancy counts words already returning from SRAM, so the 2-entry FIFO never overflows.
  assign fifo_occ    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = load_busy && (issue_left != '0) && (fifo_occ < 3'd2);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? rd_ptr_addr : '0;

  always_comb begin
    // NOTE: default first so every path assigns l_next and no latch is inferred.
    l_next = l_state;
    case (l_state)
      L_IDLE:  if (load_start && load_len != '0) l_next = L_FILL;
      L_FILL:  if (fifo_cnt == 2'd2 || LEN_WIDTH'(fifo_cnt) == beat_left) l_next = L_SEND;
      L_SEND:  if (pop && m_last) l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  // NOTE: the two FIFO words are reset too; they are tiny and m_data must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_state     <= L_IDLE;
      load_done   <= 1'b0;
      rd_ptr_addr <= '0;
      issue_left  <= '0;
      beat_left   <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      l_state   <= l_next;
      load_done <= (load_accept && load_len == '0) || (pop && m_last);
      inflight  <= issue;
      if (load_accept) begin
        rd_ptr_addr <= load_base;
        issue_left  <= load_len;
        beat_left   <= load_len;
      end else begin
        if (issue) begin
          rd_ptr_addr <= rd_ptr_addr + 1'b1;
          issue_left  <= issue_left - 1'b1;
        end
        if (pop) beat_left <= beat_left - 1'b1;
      end
      if (inflight) begin
        fifo_mem[fifo_wr_ptr] <= mem_rd_data;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef IFMAP_DMA_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            tx_stall_cnt <= 16'h0000;
    else if (load_accept)                               tx_stall_cnt <= 16'h0000;
    else if (m_valid && !m_ready && tx_stall_cnt != 16'hFFFF) tx_stall_cnt <= tx_stall_cnt + 16'h0001;
  end
`endif

  // ---------------- drainer ----------------
  drain_state_t          d_state, d_next;
  logic [ADDR_WIDTH-1:0] drain_base_r;
  logic [LEN_WIDTH-1:0]  drain_len_r, wr_cnt, wr_cnt_next;
  logic                  drain_accept, beat, finish, early;

  assign drain_accept = drain_start && (d_state == D_IDLE);
  assign s_ready      = (d_state == D_RUN);
  assign drain_busy   = s_ready;
  assign beat         = s_valid && s_ready;
  assign wr_cnt_next  = wr_cnt + {{(LEN_WIDTH-1){1'b0}}, beat};
  // Completion wins over s_last in the same cycle: an end marker on the final beat is normal.
  assign finish       = s_ready && (wr_cnt_next == drain_len_r);
  assign early        = s_ready && !finish && s_last;
  assign mem_wr_en    = beat;
  assign mem_wr_addr  = beat ? drain_base_r + ADDR_WIDTH'(wr_cnt) : '0;
  assign mem_wr_data  = beat ? s_data : '0;

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: if (drain_accept && drain_len != '0) d_next = D_RUN;
      D_RUN:  if (finish || early) d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state      <= D_IDLE;
      drain_base_r <= '0;
      drain_len_r  <= '0;
      wr_cnt       <= '0;
      drain_done   <= 1'b0;
      drain_err    <= 1'b0;
    end else begin
      d_state    <= d_next;
      drain_done <= (drain_accept && drain_len == '0) || finish || early;
      if (drain_accept) begin
        drain_base_r <= drain_base;
        drain_len_r  <= drain_len;
        wr_cnt       <= '0;
        drain_err    <= 1'b0;
      end else begin
        wr_cnt <= wr_cnt_next;
        if (early) drain_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifmap_stream_dma.sv
// Self-checking bench for ifmap_stream_dma: behavioural transfer model checked every cycle,
// directed scenarios with literal expectations, then randomized concurrent load/drain traffic.
module tb_ifmap_stream_dma;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, drain_start, m_ready, s_valid, s_last;
  logic [15:0] load_base, load_len, drain_base, drain_len;
  logic        mem_rd_en, mem_wr_en, m_valid, m_last, s_ready;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data, m_data, s_data;
  logic        load_busy, load_done, drain_busy, drain_done, drain_err;
`ifdef IFMAP_DMA_STALL_CNT_EN
  logic [15:0] tx_stall_cnt;
  logic [15:0] stall_exp;
`endif

  always #5 clk = ~clk;

  ifmap_stream_dma dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done),
    .drain_busy(drain_busy), .drain_done(drain_done), .drain_err(drain_err)
`ifdef IFMAP_DMA_STALL_CNT_EN
    , .tx_stall_cnt(tx_stall_cnt)
`endif
  );

  function automatic logic [31:0] sram_val(input logic [15:0] a);
    return {~a, a};
  endfunction

  // SRAM with exactly one cycle of read latency; garbage when no read was issued.
  logic        rd_req;
  logic [15:0] rd_a;
  always @(negedge clk) begin
    rd_req <= mem_rd_en;
    rd_a   <= mem_rd_addr;
  end
  always @(posedge clk) mem_rd_data <= rd_req ? sram_val(rd_a) : $urandom();

  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state and observations (written only by the compare process)
  bit          l_active, l_done_due, l_vseen;
  logic [15:0] l_base;
  int          l_len, l_sent, l_issued, l_age;
  bit          d_run, d_err, d_done_due;
  logic [15:0] d_base;
  int          d_len, d_k;
  logic [31:0] obs_beats[$];
  logic [31:0] wmem[logic [15:0]];
  int          load_done_cnt, drain_done_cnt, rd_cnt, wr_cnt;
  logic [31:0] feed_q[$];

  always @(negedge clk) begin
    bit was_l, beat;
    int k2;
    if (rst) begin
      check("reset_outputs", {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, m_data,
                              m_valid, m_last, s_ready, load_busy, load_done, drain_busy,
                              drain_done, drain_err}, '0);
`ifdef IFMAP_DMA_STALL_CNT_EN
      check("reset_stall_cnt", tx_stall_cnt, 0);
      stall_exp = 0;
`endif
      l_active = 0; l_done_due = 0; d_run = 0; d_err = 0; d_done_due = 0;
    end else begin
      // loader: order, last flag, no valid gaps, read addresses, done timing
      check("load_done", load_done, l_done_due);
      check("load_busy", load_busy, l_active);
      if (load_done) load_done_cnt++;
      l_done_due = 0;
      was_l = l_active;
      if (!l_active) begin
        check("load_idle_quiet", {m_valid, m_last, mem_rd_en}, 0);
      end else begin
        l_age++;
        if (mem_rd_en) begin
          rd_cnt++;
          check("rd_addr", {l_issued < l_len, mem_rd_addr}, {1'b1, 16'(l_base + 16'(l_issued))});
          l_issued++;
        end
        if (l_vseen) check("m_valid_hold", m_valid, 1);
        else if (!m_valid && l_age > 12) begin
          check("first_beat_timeout", 0, 1);
          l_active = 0;
        end
        if (m_valid) begin
          l_vseen = 1;
          check("m_valid_early", l_age >= 2, 1);
          check("m_data", m_data, sram_val(16'(l_base + 16'(l_sent))));
          check("m_last", m_last, l_sent == l_len - 1);
          if (m_ready) begin
            obs_beats.push_back(m_data);
            l_sent++;
            if (l_sent == l_len) begin l_active = 0; l_done_due = 1; end
          end
        end
      end
`ifdef IFMAP_DMA_STALL_CNT_EN
      check("tx_stall_cnt", tx_stall_cnt, stall_exp);
      if (load_start && !was_l) stall_exp = 0;
      else if (m_valid && !m_ready && stall_exp != 16'hFFFF) stall_exp++;
`endif
      if (load_start && !was_l) begin
        l_active = (load_len != 0); l_done_due = (load_len == 0);
        l_base = load_base; l_len = load_len;
        l_sent = 0; l_issued = 0; l_age = 0; l_vseen = 0;
        obs_beats.delete();
      end

      // drainer
      beat = s_valid && d_run;
      check("s_ready", s_ready, d_run);
      check("drain_busy", drain_busy, d_run);
      check("drain_done", drain_done, d_done_due);
      check("drain_err", drain_err, d_err);
      check("mem_wr_en", mem_wr_en, beat);
      if (beat) begin
        check("wr_addr_data", {mem_wr_addr, mem_wr_data}, {16'(d_base + 16'(d_k)), s_data});
        wmem[mem_wr_addr] = mem_wr_data;
        wr_cnt++;
      end
      if (drain_done) drain_done_cnt++;
      d_done_due = 0;
      if (d_run) begin
        k2 = d_k + int'(beat);
        if (k2 == d_len) begin d_run = 0; d_done_due = 1; end
        else if (s_last) begin d_err = 1; d_run = 0; d_done_due = 1; end
        d_k = k2;
      end else if (drain_start) begin
        d_err = 0; d_k = 0; d_base = drain_base; d_len = drain_len;
        if (drain_len == 0) d_done_due = 1; else d_run = 1;
      end
    end
  end

  // m_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
  int ready_mode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic start_load(input logic [15:0] b, input logic [15:0] n, input bit again);
    @(posedge clk); #1;
    load_start = 1'b1; load_base = b; load_len = n;
    @(posedge clk); #1;
    if (again) begin
      load_base = b + 16'h0055; load_len = n + 16'd1;
      @(posedge clk); #1;
    end
    load_start = 1'b0;
  endtask

  task automatic wait_load_idle();
    int c = 0;
    @(posedge clk); #1;
    while (load_busy && c < 400) begin @(posedge clk); #1; c++; end
    check("load_idle_timeout", c < 400, 1);
    @(posedge clk); #1;
  endtask

  task automatic start_drain(input logic [15:0] b, input logic [15:0] n, input bit again);
    @(posedge clk); #1;
    drain_start = 1'b1; drain_base = b; drain_len = n;
    @(posedge clk); #1;
    if (again) begin
      drain_base = b + 16'h0033; drain_len = n + 16'd2;
      @(posedge clk); #1;
    end
    drain_start = 1'b0;
  endtask

  // Offers n beats, then an end marker either on the n-th beat or one cycle after it.
  task automatic feed_drain(input int n, input bit coincide);
    int acc = 0;
    int cyc = 0;
    bit fin = 0;
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      s_last = 1'b0;
      if (acc >= n) begin
        s_valid = 1'b0; s_last = 1'b1; fin = 1;
      end else begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = (acc < feed_q.size()) ? feed_q[acc] : $urandom();
        if (s_valid && s_ready) begin
          if (coincide && acc == n - 1) begin s_last = 1'b1; fin = 1; end
          acc++;
        end
      end
    end
    check("feed_timeout", fin, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int ld0, dd0, rd0, wr0, c;

  initial begin
    rst = 1'b1;
    load_start = 0; load_base = 0; load_len = 0;
    drain_start = 0; drain_base = 0; drain_len = 0;
    s_valid = 0; s_last = 0; s_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // load 4 words from 0x10 at full rate
    ld0 = load_done_cnt;
    start_load(16'h0010, 16'd4, 0);
    wait_load_idle();
    check("t1_beats", obs_beats.size(), 4);
    check("t1_first_word", obs_beats.size() > 0 ? obs_beats[0] : 32'h0, 32'hFFEF_0010);
    check("t1_last_word", obs_beats.size() > 3 ? obs_beats[3] : 32'h0, 32'hFFEC_0013);
    check("t1_done_pulses", load_done_cnt - ld0, 1);

    // load 8 words with toggling m_ready
    ready_mode = 1;
    start_load(16'h0100, 16'd8, 0);
    wait_load_idle();
    check("t2_beats", obs_beats.size(), 8);
    check("t2_last_word", obs_beats.size() > 7 ? obs_beats[7] : 32'h0, 32'hFEF8_0107);
`ifdef IFMAP_DMA_STALL_CNT_EN
    check("t2_stall_7_or_8", tx_stall_cnt == 16'd7 || tx_stall_cnt == 16'd8, 1);
`endif
    ready_mode = 0;

    // zero-length load
    ld0 = load_done_cnt; rd0 = rd_cnt;
    start_load(16'h0200, 16'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_done_pulses", load_done_cnt - ld0, 1);
    check("t3_no_reads", rd_cnt - rd0, 0);

    // drain 3 words to 0x40
    wmem.delete();
    feed_q = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    dd0 = drain_done_cnt; wr0 = wr_cnt;
    start_drain(16'h0040, 16'd3, 0);
    feed_drain(3, 0);
    check("t4_w40", wmem[16'h0040], 32'hAAAA_0001);
    check("t4_w41", wmem[16'h0041], 32'hBBBB_0002);
    check("t4_w42", wmem[16'h0042], 32'hCCCC_0003);
    check("t4_writes", wr_cnt - wr0, 3);
    check("t4_done_err", {drain_done_cnt - dd0, drain_err}, {32'd1, 1'b0});
    feed_q.delete();

    // early end marker after 2 of 5 beats
    dd0 = drain_done_cnt; wr0 = wr_cnt;
    start_drain(16'h0080, 16'd5, 0);
    feed_drain(2, 0);
    check("t5_writes", wr_cnt - wr0, 2);
    check("t5_err", drain_err, 1);
    check("t5_done_pulses", drain_done_cnt - dd0, 1);

    // reset in the middle of a 6-word load, then a fresh load
    start_load(16'h0300, 16'd6, 0);
    c = 0;
    while (obs_beats.size() < 2 && c < 50) begin @(posedge clk); #1; c++; end
    check("t6_reach_beat2", c < 50, 1);
    rst = 1'b1;
    #1 check("t6_rst_immediate", {m_valid, load_busy, mem_rd_en}, 0);
    ld0 = load_done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("t6_no_done", load_done_cnt - ld0, 0);
    start_load(16'h0300, 16'd6, 0);
    wait_load_idle();
    check("t6_reload_beats", obs_beats.size(), 6);

    // randomized concurrent traffic
    for (int it = 0; it < 40; it++) begin
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      fork
        begin
          logic [15:0] b, n;
          b = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom());
          n = 16'($urandom_range(0, 10));
          start_load(b, n, (n >= 1) && ($urandom_range(0, 1) == 1));
          if (n > 0) wait_load_idle(); else repeat (3) @(posedge clk);
        end
        begin
          logic [15:0] b, n;
          int mode;
          b = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom());
          n = 16'($urandom_range(0, 8));
          mode = $urandom_range(0, 2);
          start_drain(b, n, (n >= 1) && ($urandom_range(0, 1) == 1));
          if (n == 0) repeat (3) @(posedge clk);
          else if (mode == 2) feed_drain($urandom_range(0, int'(n) - 1), 0);
          else feed_drain(int'(n), mode == 1);
        end
      join
    end
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
